// File: rtl/module_operand_entry_fsm_pkg.sv
// -----------------------------------------------------------------------------
// pkg_operand_entry
// Shared definitions for the operand entry sequencer: the FSM state type,
// default key codes and timeout, and a digit-classification helper.
// -----------------------------------------------------------------------------
package pkg_operand_entry;

    localparam int unsigned KEY_W   = 4;
    localparam int unsigned STATE_W = 3;

    // Entry sequence order; the encoding is visible on state_o for debug.
    typedef enum logic [STATE_W-1:0] {
        WAIT_A = 3'd0,
        LOAD_A = 3'd1,
        WAIT_B = 3'd2,
        LOAD_B = 3'd3,
        READY  = 3'd4
    } state_t;

    localparam int unsigned      DIGIT_MAX_DEF   = 9;
    localparam logic [KEY_W-1:0] KEY_ENTER_DEF   = 4'hA;
    localparam logic [KEY_W-1:0] KEY_CLEAR_DEF   = 4'hC;
    localparam int unsigned      TIMEOUT_CYC_DEF = 100_000_000;

    // A code is a digit when it lies in 0..dmax.
    function automatic logic is_digit(input logic [KEY_W-1:0] code,
                                      input int unsigned dmax);
        return (32'(code) <= dmax);
    endfunction

endpackage

// File: rtl/module_operand_entry_fsm_if.sv
// -----------------------------------------------------------------------------
// module_operand_entry_fsm_if
// Bundles the keypad/arithmetic-side inputs and operand-register-side outputs
// of the operand entry sequencer.
//   master : environment (keypad decoder + arithmetic stage + operand reg)
//   slave  : the sequencer itself
// Signals:
//   key_valid/key_code  1-cycle key strobe and decoded code
//   calc_done           1-cycle strobe, result consumed
//   num, load_a, load_b operand value and 1-cycle write pulses
//   operands_ready      level, both operands committed
//   staged, staged_vld  staged digit echo
//   key_err             1-cycle rejected-key pulse
//   state_o             debug state encoding
// -----------------------------------------------------------------------------
interface module_operand_entry_fsm_if;
    import pkg_operand_entry::*;

    logic               key_valid;
    logic [KEY_W-1:0]   key_code;
    logic               calc_done;
    logic [KEY_W-1:0]   num;
    logic               load_a;
    logic               load_b;
    logic               operands_ready;
    logic [KEY_W-1:0]   staged;
    logic               staged_vld;
    logic               key_err;
    logic [STATE_W-1:0] state_o;

    modport master (
        output key_valid, key_code, calc_done,
        input  num, load_a, load_b, operands_ready,
        input  staged, staged_vld, key_err, state_o
    );

    modport slave (
        input  key_valid, key_code, calc_done,
        output num, load_a, load_b, operands_ready,
        output staged, staged_vld, key_err, state_o
    );

endinterface

// File: rtl/module_operand_entry_fsm_timeout.sv
// -----------------------------------------------------------------------------
// module_entry_timeout
// Idle counter for the second-operand wait. Counts while enable is high and
// clear is low; expire is asserted combinationally in the cycle the count has
// reached TIMEOUT_CYC-1, so the owner leaves after exactly TIMEOUT_CYC idle
// cycles. The count saturates instead of wrapping. TIMEOUT_CYC=0 disables it.
// Ports:
//   clk, rst  clock, asynchronous active-low reset
//   enable    count this cycle
//   clear     restart from zero (wins over enable)
//   expire    idle limit reached this cycle
// -----------------------------------------------------------------------------
module module_entry_timeout #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    // Keep at least one bit so the disabled/trivial cases still elaborate.
    localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam bit          TO_EN = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (!TO_EN || clear || !enable) begin
            count_d = '0;
        end else if (count_q != CNT_LAST) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = TO_EN && enable && !clear && (count_q == CNT_LAST);

endmodule

// File: rtl/module_operand_entry_fsm.sv
// -----------------------------------------------------------------------------
// module_operand_entry_fsm
// Front-end sequencer between the keypad decoder and the operand register.
// Stages a digit, commits it as operand A on ENTER, then operand B, raises
// operands_ready and waits for calc_done before starting over.
// Ports:
//   clk   system clock
//   rst   asynchronous active-low reset
//   bus   slave side of module_operand_entry_fsm_if (keys, calc_done in;
//         num/load_a/load_b/operands_ready/staged/staged_vld/key_err/state_o out)
// -----------------------------------------------------------------------------
module module_operand_entry_fsm
    import pkg_operand_entry::*;
#(
    parameter int unsigned      DIGIT_MAX   = DIGIT_MAX_DEF,
    parameter logic [KEY_W-1:0] KEY_ENTER   = KEY_ENTER_DEF,
    parameter logic [KEY_W-1:0] KEY_CLEAR   = KEY_CLEAR_DEF,
    parameter int unsigned      TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    module_operand_entry_fsm_if.slave  bus
);

    state_t           state_q, state_d;
    logic [KEY_W-1:0] staged_q, staged_d;
    logic             staged_vld_q, staged_vld_d;
    logic [KEY_W-1:0] num_q, num_d;
    logic             key_err_q, key_err_d;

    logic key_digit;
    logic key_enter;
    logic key_clear;
    logic key_bad;
    logic to_enable;
    logic to_expire;

    assign key_digit = bus.key_valid && is_digit(bus.key_code, DIGIT_MAX);
    assign key_enter = bus.key_valid && (bus.key_code == KEY_ENTER);
    assign key_clear = bus.key_valid && (bus.key_code == KEY_CLEAR);
    assign key_bad   = bus.key_valid && !key_digit && !key_enter && !key_clear;

    // Any key press, accepted or not, counts as activity.
    assign to_enable = (state_q == WAIT_B);

    module_entry_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .enable (to_enable),
        .clear  (bus.key_valid),
        .expire (to_expire)
    );

    always_comb begin
        state_d      = state_q;
        staged_d     = staged_q;
        staged_vld_d = staged_vld_q;
        num_d        = num_q;
        key_err_d    = 1'b0;

        unique case (state_q)
            WAIT_A, WAIT_B: begin
                if (key_clear) begin
                    state_d      = WAIT_A;
                    staged_vld_d = 1'b0;
                end else if (key_digit) begin
                    staged_d     = bus.key_code;
                    staged_vld_d = 1'b1;
                end else if (key_enter) begin
                    if (staged_vld_q) begin
                        // num is loaded here so it is already stable while
                        // the load pulse is high in the next cycle.
                        state_d      = (state_q == WAIT_A) ? LOAD_A : LOAD_B;
                        num_d        = staged_q;
                        staged_vld_d = 1'b0;
                    end else begin
                        key_err_d = 1'b1;
                    end
                end else if (key_bad) begin
                    key_err_d = 1'b1;
                end else if (to_expire) begin
                    state_d      = WAIT_A;
                    staged_vld_d = 1'b0;
                end
            end
            // Keys (including CLEAR) are dropped during the one load cycle.
            LOAD_A: state_d = WAIT_B;
            LOAD_B: state_d = READY;
            READY: begin
                if (key_clear || bus.calc_done) begin
                    state_d = WAIT_A;
                end else if (key_bad) begin
                    key_err_d = 1'b1;
                end
            end
            default: begin
                state_d      = WAIT_A;
                staged_vld_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= WAIT_A;
            staged_q     <= '0;
            staged_vld_q <= 1'b0;
            num_q        <= '0;
            key_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            staged_q     <= staged_d;
            staged_vld_q <= staged_vld_d;
            num_q        <= num_d;
            key_err_q    <= key_err_d;
        end
    end

    // Pulses decode straight from the state register so they fall the
    // instant reset is asserted.
    assign bus.num            = num_q;
    assign bus.load_a         = (state_q == LOAD_A);
    assign bus.load_b         = (state_q == LOAD_B);
    assign bus.operands_ready = (state_q == READY);
    assign bus.staged         = staged_q;
    assign bus.staged_vld     = staged_vld_q;
    assign bus.key_err        = key_err_q;
    assign bus.state_o        = state_q;

endmodule

// File: tb/tb_module_operand_entry_fsm.sv
// -----------------------------------------------------------------------------
// tb_module_operand_entry_fsm
// Directed scenarios plus randomized key traffic for module_operand_entry_fsm,
// checked against a transaction-level reference model (entry phase, staged
// digit, pending load, silent-cycle count). Timeout shortened to 16 cycles.
// -----------------------------------------------------------------------------
module tb_module_operand_entry_fsm;

    localparam int TO     = 16;
    localparam int ENTER  = 10;
    localparam int CLEAR  = 12;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    module_operand_entry_fsm_if bus ();

    module_operand_entry_fsm #(
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: phase 0 = collecting A, 1 = collecting B, 2 = ready.
    int m_phase;
    bit m_load_a, m_load_b, m_have, m_err;
    int m_staged, m_num, m_silent;

    function automatic void model_reset();
        m_phase  = 0;
        m_load_a = 0;
        m_load_b = 0;
        m_have   = 0;
        m_err    = 0;
        m_staged = 0;
        m_num    = 0;
        m_silent = 0;
    endfunction

    function automatic int m_state();
        if (m_load_a) return 1;
        if (m_load_b) return 3;
        return m_phase * 2;
    endfunction

    function automatic void model_step(bit kv, int kc, bit cd);
        bit waiting_b;
        waiting_b = (m_phase == 1) && !m_load_b;
        m_err = 0;
        if (waiting_b && !kv) m_silent++;
        else                  m_silent = 0;

        if (m_load_a) begin
            m_load_a = 0;
            m_phase  = 1;
        end else if (m_load_b) begin
            m_load_b = 0;
            m_phase  = 2;
        end else if (m_phase == 2) begin
            if ((kv && kc == CLEAR) || cd) m_phase = 0;
            else if (kv && kc > 9 && kc != ENTER && kc != CLEAR) m_err = 1;
        end else begin
            if (kv && kc == CLEAR) begin
                m_phase = 0;
                m_have  = 0;
            end else if (kv && kc <= 9) begin
                m_staged = kc;
                m_have   = 1;
            end else if (kv && kc == ENTER) begin
                if (m_have) begin
                    m_num  = m_staged;
                    m_have = 0;
                    if (m_phase == 0) m_load_a = 1;
                    else              m_load_b = 1;
                end else begin
                    m_err = 1;
                end
            end else if (kv) begin
                m_err = 1;
            end else if (waiting_b && m_silent == TO) begin
                m_phase = 0;
                m_have  = 0;
            end
        end
    endfunction

    // One clock: drive at negedge, step the model at posedge, settle 1 unit.
    task automatic tick(input bit kv, input int kc, input bit cd);
        @(negedge clk);
        bus.key_valid = kv;
        bus.key_code  = 4'(kc);
        bus.calc_done = cd;
        @(posedge clk);
        model_step(kv, kc, cd);
        #1;
        bus.key_valid = 1'b0;
        bus.calc_done = 1'b0;
    endtask

    task automatic test_reset();
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        bus.calc_done = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.state_o !== 3'd0) $display("FAIL reset state_o: got %0d want 0", bus.state_o); else n_pass++;
        n_checks++; if (bus.num !== 4'd0) $display("FAIL reset num: got %0d want 0", bus.num); else n_pass++;
        n_checks++; if (bus.staged !== 4'd0 || bus.staged_vld !== 1'b0) $display("FAIL reset staged: got %0d/%b want 0/0", bus.staged, bus.staged_vld); else n_pass++;
        n_checks++; if ({bus.load_a, bus.load_b, bus.operands_ready, bus.key_err} !== 4'b0) $display("FAIL reset strobes: got %b want 0000", {bus.load_a, bus.load_b, bus.operands_ready, bus.key_err}); else n_pass++;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_entry();
        tick(1, 3, 0);
        n_checks++; if (bus.staged !== 4'd3 || bus.staged_vld !== 1'b1) $display("FAIL basic staged: got %0d/%b want 3/1", bus.staged, bus.staged_vld); else n_pass++;
        tick(1, ENTER, 0);
        n_checks++; if (bus.load_a !== 1'b1 || bus.num !== 4'd3) $display("FAIL basic load_a: got %b num %0d want 1 num 3", bus.load_a, bus.num); else n_pass++;
        tick(0, 0, 0);
        n_checks++; if (bus.load_a !== 1'b0 || bus.state_o !== 3'd2) $display("FAIL basic after_a: got load_a %b state %0d want 0 state 2", bus.load_a, bus.state_o); else n_pass++;
        tick(1, 7, 0);
        tick(1, ENTER, 0);
        n_checks++; if (bus.load_b !== 1'b1 || bus.load_a !== 1'b0 || bus.num !== 4'd7) $display("FAIL basic load_b: got %b/%b num %0d want 1/0 num 7", bus.load_b, bus.load_a, bus.num); else n_pass++;
        tick(0, 0, 0);
        n_checks++; if (bus.operands_ready !== 1'b1 || bus.load_b !== 1'b0) $display("FAIL basic ready: got %b load_b %b want 1 0", bus.operands_ready, bus.load_b); else n_pass++;
    endtask

    task automatic test_calc_done();
        tick(0, 0, 1);
        n_checks++; if (bus.operands_ready !== 1'b0 || bus.state_o !== 3'd0) $display("FAIL calc_done: got ready %b state %0d want 0 0", bus.operands_ready, bus.state_o); else n_pass++;
        tick(1, 9, 0);
        tick(1, ENTER, 0);
        n_checks++; if (bus.load_a !== 1'b1 || bus.num !== 4'd9) $display("FAIL repeat load_a: got %b num %0d want 1 num 9", bus.load_a, bus.num); else n_pass++;
        tick(0, 0, 0);
        tick(1, 0, 0);
        tick(1, ENTER, 0);
        n_checks++; if (bus.load_b !== 1'b1 || bus.num !== 4'd0) $display("FAIL repeat load_b: got %b num %0d want 1 num 0", bus.load_b, bus.num); else n_pass++;
        tick(0, 0, 0);
        tick(0, 0, 1);
    endtask

    task automatic test_overwrite_empty_enter();
        tick(1, 2, 0);
        tick(1, 5, 0);
        tick(1, ENTER, 0);
        n_checks++; if (bus.load_a !== 1'b1 || bus.num !== 4'd5) $display("FAIL overwrite load_a: got %b num %0d want 1 num 5", bus.load_a, bus.num); else n_pass++;
        tick(0, 0, 0);
        tick(1, ENTER, 0);
        n_checks++; if (bus.key_err !== 1'b1 || bus.load_b !== 1'b0 || bus.state_o !== 3'd2) $display("FAIL empty_enter: got err %b load_b %b state %0d want 1 0 2", bus.key_err, bus.load_b, bus.state_o); else n_pass++;
        tick(0, 0, 0);
        n_checks++; if (bus.key_err !== 1'b0) $display("FAIL key_err_width: got %b want 0", bus.key_err); else n_pass++;
    endtask

    task automatic test_bad_keys_ready();
        tick(1, 15, 0);
        n_checks++; if (bus.key_err !== 1'b1 || bus.state_o !== 3'd2) $display("FAIL bad_key_F: got err %b state %0d want 1 2", bus.key_err, bus.state_o); else n_pass++;
        tick(1, 11, 0);
        n_checks++; if (bus.key_err !== 1'b1 || bus.state_o !== 3'd2) $display("FAIL bad_key_B: got err %b state %0d want 1 2", bus.key_err, bus.state_o); else n_pass++;
        tick(1, 6, 0);
        tick(1, ENTER, 0);
        tick(0, 0, 0);
        tick(1, 4, 0);
        n_checks++; if (bus.key_err !== 1'b0 || bus.load_a !== 1'b0 || bus.state_o !== 3'd4) $display("FAIL ready_digit: got err %b load_a %b state %0d want 0 0 4", bus.key_err, bus.load_a, bus.state_o); else n_pass++;
        tick(1, ENTER, 0);
        n_checks++; if (bus.key_err !== 1'b0 || bus.load_b !== 1'b0 || bus.state_o !== 3'd4) $display("FAIL ready_enter: got err %b load_b %b state %0d want 0 0 4", bus.key_err, bus.load_b, bus.state_o); else n_pass++;
        tick(0, 0, 1);
    endtask

    task automatic test_clear_timeout();
        tick(1, 1, 0);
        tick(1, ENTER, 0);
        tick(0, 0, 0);
        tick(1, 8, 0);
        tick(1, CLEAR, 0);
        n_checks++; if (bus.state_o !== 3'd0 || bus.staged_vld !== 1'b0 || bus.load_b !== 1'b0) $display("FAIL clear: got state %0d vld %b load_b %b want 0 0 0", bus.state_o, bus.staged_vld, bus.load_b); else n_pass++;
        n_checks++; if (bus.num !== 4'd1) $display("FAIL clear_num_held: got %0d want 1", bus.num); else n_pass++;
        tick(1, 2, 0);
        tick(1, ENTER, 0);
        tick(0, 0, 0);
        tick(1, 3, 0);
        for (int i = 0; i < TO - 1; i++) tick(0, 0, 0);
        n_checks++; if (bus.state_o !== 3'd2 || bus.staged_vld !== 1'b1) $display("FAIL timeout_early: got state %0d vld %b want 2 1", bus.state_o, bus.staged_vld); else n_pass++;
        tick(0, 0, 0);
        n_checks++; if (bus.state_o !== 3'd0 || bus.staged_vld !== 1'b0 || bus.load_b !== 1'b0) $display("FAIL timeout_abort: got state %0d vld %b load_b %b want 0 0 0", bus.state_o, bus.staged_vld, bus.load_b); else n_pass++;
    endtask

    task automatic test_async_reset();
        tick(1, 4, 0);
        tick(1, ENTER, 0);
        n_checks++; if (bus.load_a !== 1'b1) $display("FAIL pre_reset load_a: got %b want 1", bus.load_a); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.load_a !== 1'b0 || bus.num !== 4'd0 || bus.state_o !== 3'd0) $display("FAIL async_reset: got load_a %b num %0d state %0d want 0 0 0", bus.load_a, bus.num, bus.state_o); else n_pass++;
        n_checks++; if (bus.staged !== 4'd0 || bus.staged_vld !== 1'b0) $display("FAIL async_reset staged: got %0d/%b want 0/0", bus.staged, bus.staged_vld); else n_pass++;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick(1, 8, 0);
        tick(1, ENTER, 0);
        n_checks++; if (bus.load_a !== 1'b1 || bus.num !== 4'd8) $display("FAIL post_reset load_a: got %b num %0d want 1 num 8", bus.load_a, bus.num); else n_pass++;
        tick(0, 0, 0);
        tick(1, CLEAR, 0);
    endtask

    task automatic test_random();
        int idle_run = 0;
        bit kv, cd;
        int kc, r;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            kv = 0; kc = 0; cd = 0;
            if (idle_run > 0) begin
                idle_run--;
            end else if ($urandom_range(0, 99) < 3) begin
                idle_run = $urandom_range(10, 20);
            end else begin
                kv = ($urandom_range(0, 99) < 60);
                r  = $urandom_range(0, 99);
                if (r < 50)      kc = $urandom_range(0, 9);
                else if (r < 75) kc = ENTER;
                else if (r < 80) kc = CLEAR;
                else             kc = $urandom_range(0, 15);
                cd = ($urandom_range(0, 99) < 10);
            end
            tick(kv, kc, cd);
            n_checks++; if (bus.state_o !== 3'(m_state())) $display("FAIL rand state_o cyc %0d: got %0d want %0d", cyc, bus.state_o, m_state()); else n_pass++;
            n_checks++; if (bus.load_a !== m_load_a || bus.load_b !== m_load_b) $display("FAIL rand loads cyc %0d: got %b%b want %b%b", cyc, bus.load_a, bus.load_b, m_load_a, m_load_b); else n_pass++;
            n_checks++; if (bus.num !== 4'(m_num)) $display("FAIL rand num cyc %0d: got %0d want %0d", cyc, bus.num, m_num); else n_pass++;
            n_checks++; if (bus.operands_ready !== (m_phase == 2)) $display("FAIL rand ready cyc %0d: got %b want %b", cyc, bus.operands_ready, m_phase == 2); else n_pass++;
            n_checks++; if (bus.staged !== 4'(m_staged) || bus.staged_vld !== m_have) $display("FAIL rand staged cyc %0d: got %0d/%b want %0d/%b", cyc, bus.staged, bus.staged_vld, m_staged, m_have); else n_pass++;
            n_checks++; if (bus.key_err !== m_err) $display("FAIL rand key_err cyc %0d: got %b want %b", cyc, bus.key_err, m_err); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_entry();
        test_calc_done();
        test_overwrite_empty_enter();
        test_bad_keys_ready();
        test_clear_timeout();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
